// File: rtl/btn_conditioner_pkg.sv
// Shared constants for the calculator button front end: clock rate,
// default debounce length and the one-hot operation select encodings.
package btn_conditioner_pkg;

    localparam int CLK_HZ       = 50_000_000;
    localparam int N_BTN_DEF    = 4;
    localparam int DB_COUNT_DEF = 500_000;

    localparam logic [3:0] MODE_ADD  = 4'b1000;
    localparam logic [3:0] MODE_MUL  = 4'b0100;
    localparam logic [3:0] MODE_XOR  = 4'b0010;
    localparam logic [3:0] MODE_CNT  = 4'b0001;
    localparam logic [3:0] MODE_PASS = 4'b0000;

endpackage

// File: rtl/debounce_bit.sv
// One button lane: two-flop synchronizer, stable-level counter debounce,
// and a combinational rise flag that is high on the edge the stable level goes 0->1.
module debounce_bit #(
    parameter int DB_COUNT = 4
) (
    input  logic clk_pi,
    input  logic rst_n_pi,
    input  logic raw_pi,
    output logic level_po,
    output logic rise_po
);
    localparam int CNT_W = $clog2(DB_COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Any return to the stable level restarts the count from zero.
    always_comb begin
        stable_next = stable;
        cnt_next    = '0;
        if (sync2 != stable) begin
            if (cnt == CNT_LAST) begin
                stable_next = sync2;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= raw_pi;
            sync2  <= sync1;
            stable <= stable_next;
            cnt    <= cnt_next;
        end
    end

    assign level_po = stable;
    assign rise_po  = stable_next & ~stable;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the raw push-buttons, emits one-cycle press pulses and keeps a
// latched one-hot operation select that the user toggles by tapping a button.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int N_BTN    = N_BTN_DEF,
    parameter int DB_COUNT = DB_COUNT_DEF
) (
    input  logic             clk_pi,
    input  logic             rst_n_pi,
    input  logic [N_BTN-1:0] btn_raw_pi,
    output logic [N_BTN-1:0] btn_level_po,
    output logic [N_BTN-1:0] btn_press_po,
    output logic [N_BTN-1:0] mode_po
);
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] sel;
    logic [N_BTN-1:0] mode_next;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        debounce_bit #(
            .DB_COUNT(DB_COUNT)
        ) u_db (
            .clk_pi  (clk_pi),
            .rst_n_pi(rst_n_pi),
            .raw_pi  (btn_raw_pi[gi]),
            .level_po(btn_level_po[gi]),
            .rise_po (rise[gi])
        );
    end

    // Ascending scan so the highest-index simultaneous rise owns the select.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (rise[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
        mode_next = mode_po;
        if (rise != '0) begin
            mode_next = (mode_po == sel) ? '0 : sel;
        end
    end

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            btn_press_po <= '0;
            mode_po      <= '0;
        end else begin
            btn_press_po <= rise;
            mode_po      <= mode_next;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with a short debounce length: table of held levels,
// plus hand-built glitch, bounce and reset sequences, checked through an edge-stamped scoreboard.
module tb_btn_conditioner;
    import btn_conditioner_pkg::*;

    localparam int NB  = 4;
    localparam int DBC = 4;
    localparam int LAT = DBC + 2;

    logic          clk_pi = 1'b0;
    logic          rst_n_pi = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] mode;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    btn_conditioner #(
        .N_BTN(NB),
        .DB_COUNT(DBC)
    ) dut (
        .clk_pi      (clk_pi),
        .rst_n_pi    (rst_n_pi),
        .btn_raw_pi  (btn_raw),
        .btn_level_po(btn_level),
        .btn_press_po(btn_press),
        .mode_po     (mode)
    );

    always #5 clk_pi = ~clk_pi;
    always @(posedge clk_pi) edge_n <= edge_n + 1;

    typedef struct {
        int            edge_no;
        logic [NB-1:0] level;
        logic [NB-1:0] press;
        logic [NB-1:0] mode;
        string         name;
    } exp_t;

    typedef struct {
        logic [NB-1:0] raw;
        int            hold;
        logic [NB-1:0] level;
        logic [NB-1:0] press;
        logic [NB-1:0] mode;
        string         name;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    vec_t vec[8];

    task automatic push(input int e, input logic [NB-1:0] lv, input logic [NB-1:0] pr,
                        input logic [NB-1:0] md, input string nm);
        exp_t x;
        x.edge_no = e;
        x.level   = lv;
        x.press   = pr;
        x.mode    = md;
        x.name    = nm;
        sb.push_back(x);
    endtask

    task automatic check_now(input string nm, input logic [NB-1:0] lv,
                             input logic [NB-1:0] pr, input logic [NB-1:0] md);
        checks++;
        if ({btn_level, btn_press, mode} !== {lv, pr, md}) begin
            errors++;
            $display("FAIL %s: level/press/mode got %b/%b/%b want %b/%b/%b",
                     nm, btn_level, btn_press, mode, lv, pr, md);
        end
    endtask

    // Scoreboard monitor: compares each queued expectation 1 time unit after its edge.
    always @(posedge clk_pi) begin
        #1;
        while (sb.size() > 0 && sb[0].edge_no <= edge_n) begin
            cur = sb.pop_front();
            if (cur.edge_no != edge_n) begin
                checks++;
                errors++;
                $display("FAIL %s: checked at edge %0d want edge %0d", cur.name, edge_n, cur.edge_no);
            end else begin
                check_now(cur.name, cur.level, cur.press, cur.mode);
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk_pi);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations pending want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [NB-1:0] prev_level;
        logic [NB-1:0] prev_mode;

        vec[0] = '{4'b1000, 10, 4'b1000, 4'b1000, MODE_ADD,  "press_add"};
        vec[1] = '{4'b0000, 10, 4'b0000, 4'b0000, MODE_ADD,  "release_add"};
        vec[2] = '{4'b1000, 10, 4'b1000, 4'b1000, MODE_PASS, "retap_add_off"};
        vec[3] = '{4'b0000, 10, 4'b0000, 4'b0000, MODE_PASS, "release_add2"};
        vec[4] = '{4'b0010, 10, 4'b0010, 4'b0010, MODE_XOR,  "press_xor"};
        vec[5] = '{4'b0000, 10, 4'b0000, 4'b0000, MODE_XOR,  "release_xor"};
        vec[6] = '{4'b0110, 10, 4'b0110, 4'b0110, MODE_MUL,  "press_mul_xor"};
        vec[7] = '{4'b0000, 10, 4'b0000, 4'b0000, MODE_MUL,  "release_mul_xor"};

        repeat (3) @(negedge clk_pi);
        check_now("reset_state", 4'b0000, 4'b0000, 4'b0000);
        rst_n_pi = 1'b1;
        repeat (2) @(negedge clk_pi);

        prev_level = '0;
        prev_mode  = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_pi);
            btn_raw = vec[i].raw;
            c = edge_n;
            push(c + LAT - 1, prev_level, 4'b0000, prev_mode, {vec[i].name, "_pre"});
            push(c + LAT, vec[i].level, vec[i].press, vec[i].mode, vec[i].name);
            push(c + LAT + 1, vec[i].level, 4'b0000, vec[i].mode, {vec[i].name, "_post"});
            repeat (vec[i].hold) @(negedge clk_pi);
            wait_drain();
            prev_level = vec[i].level;
            prev_mode  = vec[i].mode;
        end

        // Pulse of DB_COUNT-1 cycles on the mul button: must be ignored.
        @(negedge clk_pi);
        btn_raw = 4'b0100;
        c = edge_n;
        for (int k = 4; k <= 12; k++) push(c + k, 4'b0000, 4'b0000, MODE_MUL, "short_glitch");
        repeat (3) @(negedge clk_pi);
        btn_raw = 4'b0000;
        wait_drain();

        // Pulse of exactly DB_COUNT cycles: accepted, toggles mul off, then falls.
        @(negedge clk_pi);
        btn_raw = 4'b0100;
        c = edge_n;
        push(c + 5,  4'b0000, 4'b0000, MODE_MUL,  "exact_pulse_pre");
        push(c + 6,  4'b0100, 4'b0100, MODE_PASS, "exact_pulse_rise");
        push(c + 7,  4'b0100, 4'b0000, MODE_PASS, "exact_pulse_post");
        push(c + 9,  4'b0100, 4'b0000, MODE_PASS, "exact_pulse_hold");
        push(c + 10, 4'b0000, 4'b0000, MODE_PASS, "exact_pulse_fall");
        repeat (4) @(negedge clk_pi);
        btn_raw = 4'b0000;
        wait_drain();

        // Bounce 1,0,1,0 then hold 1 on the counter button.
        @(negedge clk_pi);
        c = edge_n;
        btn_raw = 4'b0001;
        push(c + 9,  4'b0000, 4'b0000, MODE_PASS, "bounce_pre");
        push(c + 10, 4'b0001, 4'b0001, MODE_CNT,  "bounce_rise");
        push(c + 11, 4'b0001, 4'b0000, MODE_CNT,  "bounce_post");
        @(negedge clk_pi); btn_raw = 4'b0000;
        @(negedge clk_pi); btn_raw = 4'b0001;
        @(negedge clk_pi); btn_raw = 4'b0000;
        @(negedge clk_pi); btn_raw = 4'b0001;
        wait_drain();

        // Reset mid-count with add and counter held; both rise together after release.
        @(negedge clk_pi);
        btn_raw = 4'b1001;
        repeat (3) @(negedge clk_pi);
        @(posedge clk_pi);
        #2;
        rst_n_pi = 1'b0;
        #1;
        check_now("async_reset", 4'b0000, 4'b0000, 4'b0000);
        repeat (2) @(negedge clk_pi);
        check_now("reset_held", 4'b0000, 4'b0000, 4'b0000);
        rst_n_pi = 1'b1;
        c = edge_n;
        push(c + LAT - 1, 4'b0000, 4'b0000, MODE_PASS, "post_reset_pre");
        push(c + LAT,     4'b1001, 4'b1001, MODE_ADD,  "post_reset_rise");
        push(c + LAT + 1, 4'b1001, 4'b0000, MODE_ADD,  "post_reset_post");
        repeat (10) @(negedge clk_pi);
        wait_drain();

        // Release both: level falls, no pulse, mode kept.
        @(negedge clk_pi);
        btn_raw = 4'b0000;
        c = edge_n;
        push(c + LAT - 1, 4'b1001, 4'b0000, MODE_ADD, "final_release_pre");
        push(c + LAT,     4'b0000, 4'b0000, MODE_ADD, "final_release");
        push(c + LAT + 1, 4'b0000, 4'b0000, MODE_ADD, "final_release_post");
        repeat (10) @(negedge clk_pi);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
